// File: rtl/de2_key_pkg.sv
// Shared definitions for the DE2 push-button conditioning path.
//   chan_state_t : per-key debounce state
//   cnt_width    : bits needed to hold values 0..max_val (minimum 1)
//   max_u        : larger of two unsigned values, for sizing shared counters
package de2_key_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PENDING,
    HELD,
    RELEASE_PENDING
  } chan_state_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a,
                                        input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One push-button channel: 2-flop synchroniser, debounce counter, four-state
// FSM and optional auto-repeat counter. All outputs are registered.
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   key_n          : raw key pin, active-low, asynchronous to clk
//   level          : debounced key state, 1 = pressed
//   strobe_press   : one-cycle pulse on an accepted press
//   strobe_release : one-cycle pulse on an accepted release
//   strobe_repeat  : one-cycle auto-repeat pulse while held
module key_debounce_chan
  import de2_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_RATE     = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic strobe_press,
  output logic strobe_release,
  output logic strobe_repeat
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Synchroniser; both stages reset to the released level of the pin.
  logic sync_a;
  logic sync_b;
  logic raw_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
    end
  end

  assign raw_s = ~sync_b;

  // Debounce counter: runs only while the synchronised input disagrees with
  // the accepted level; any agreeing cycle restarts it.
  logic [DW-1:0] db_cnt;
  logic          level_q;
  logic          differ;
  logic          term;

  assign differ = (raw_s != level_q);
  assign term   = differ && (db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
    end else if (!differ || term) begin
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  // FSM state register
  chan_state_t state;
  chan_state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RELEASED;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state. With DEBOUNCE_CYCLES = 1 the terminal count is already
  // true on the first disagreeing cycle, so the stable states can skip their
  // pending state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RELEASED: begin
        if (raw_s) begin
          state_nxt = term ? HELD : PRESS_PENDING;
        end
      end
      PRESS_PENDING: begin
        if (!raw_s) begin
          state_nxt = RELEASED;
        end else if (term) begin
          state_nxt = HELD;
        end
      end
      HELD: begin
        if (!raw_s) begin
          state_nxt = term ? RELEASED : RELEASE_PENDING;
        end
      end
      RELEASE_PENDING: begin
        if (raw_s) begin
          state_nxt = HELD;
        end else if (term) begin
          state_nxt = RELEASED;
        end
      end
      default: state_nxt = RELEASED;
    endcase
  end

  // FSM outputs, computed one cycle ahead and registered below.
  logic level_nxt;
  logic press_nxt;
  logic release_nxt;

  always_comb begin
    level_nxt   = 1'b0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (state_nxt == HELD || state_nxt == RELEASE_PENDING) begin
      level_nxt = 1'b1;
    end
    if (term && !level_q) begin
      press_nxt = 1'b1;
    end
    if (term && level_q) begin
      release_nxt = 1'b1;
    end
  end

  logic press_q;
  logic release_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
    end
  end

  assign level          = level_q;
  assign strobe_press   = press_q;
  assign strobe_release = release_q;

  // Auto-repeat
  generate
    if (REPEAT_DELAY == 0) begin : g_no_repeat
      assign strobe_repeat = 1'b0;
    end else begin : g_repeat
      localparam int unsigned RW = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));
      localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

      logic [RW-1:0] rpt_cnt;
      logic          first;
      logic          rpt_q;
      logic [RW-1:0] rpt_last;

      assign rpt_last = first ? DELAY_LAST : RATE_LAST;

      // The press edge clears the count, so the first pulse lands exactly
      // REPEAT_DELAY cycles after the press strobe. The release edge
      // suppresses a pulse so it can never coincide with key_release.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rpt_cnt <= '0;
          first   <= 1'b1;
          rpt_q   <= 1'b0;
        end else if (press_nxt || !level_q || release_nxt) begin
          rpt_cnt <= '0;
          first   <= 1'b1;
          rpt_q   <= 1'b0;
        end else if (rpt_cnt == rpt_last) begin
          rpt_cnt <= '0;
          first   <= 1'b0;
          rpt_q   <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + RW'(1);
          rpt_q   <= 1'b0;
        end
      end

      assign strobe_repeat = rpt_q;
    end
  endgenerate

endmodule

// File: rtl/key_debounce.sv
// DE2 push-button conditioner: N_KEYS independent debounce channels.
//   CLOCK_50    : 50 MHz system clock
//   RESET_N     : asynchronous active-low reset
//   key_in      : raw KEY pins, active-low
//   key_level   : debounced level per key, 1 = pressed
//   key_press   : one-cycle press strobe per key
//   key_release : one-cycle release strobe per key
//   key_repeat  : one-cycle auto-repeat strobe per key
module key_debounce
  import de2_key_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_RATE     = 5_000_000
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  generate
    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
      key_debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
      ) u_chan (
        .clk           (CLOCK_50),
        .rst_n         (RESET_N),
        .key_n         (key_in[i]),
        .level         (key_level[i]),
        .strobe_press  (key_press[i]),
        .strobe_release(key_release[i]),
        .strobe_repeat (key_repeat[i])
      );
    end
  endgenerate

endmodule
